// File: rtl/md_audio_mixer_if.sv
// Output stream interface of md_audio_mixer: stereo sample head, valid/ready
// handshake toward the DAC/I2S serializer, and the FIFO-drop pulse.
interface md_audio_mixer_if;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;

    modport master (
        output out_l,
        output out_r,
        output out_valid,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  out_l,
        input  out_r,
        input  out_valid,
        input  overflow,
        output out_ready
    );
endinterface

// File: rtl/md_audio_mixer.sv
// md_audio_mixer: box-filter decimation of FM (MOL/MOR) and PSG audio over a
// fixed MCLK window, scale + sum + 16-bit saturation, 4-entry FWFT output FIFO.
// Optional feature macro: MD_MIXER_LPF_EN inserts a one-pole low-pass per
// channel between saturation and the FIFO write (one extra cycle of latency).
module md_audio_mixer #(
    parameter int WINDOW    = 1008,
    parameter int FM_SHIFT  = 5,
    parameter int PSG_SHIFT = 12,
    parameter int LPF_SHIFT = 2
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic signed [8:0] MOL,
    input  logic signed [8:0] MOR,
    input  logic [15:0]       PSG,
    input  logic              MUTE,
    md_audio_mixer_if.master  out_if
);
    localparam logic [11:0] CNT_LAST = 12'(WINDOW - 1);

    // Elaboration-time guard on parameter legality.
    if (WINDOW < 2 || WINDOW > 4095 || LPF_SHIFT < 0 || LPF_SHIFT > 15) begin : g_bad_params
        $error("md_audio_mixer: illegal parameter value");
    end

    // Clamp a 29-bit signed value into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [28:0] x);
        logic signed [15:0] r;
        if (x > 29'sd32767) begin
            r = 16'sh7FFF;
        end else if (x < -29'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Window counter, accumulators and close-edge stage registers
    // ------------------------------------------------------------------
    logic [11:0]        cnt;
    logic               close;
    logic signed [19:0] mol_ext, mor_ext, acc_l, acc_r, sum_l, sum_r, stage_l, stage_r;
    logic signed [27:0] psg_ext, acc_p, sum_p, stage_p;
    logic               stage_vld;

    assign close   = (cnt == CNT_LAST);
    assign mol_ext = {{11{MOL[8]}}, MOL};
    assign mor_ext = {{11{MOR[8]}}, MOR};
    // PSG is offset binary: flipping the MSB gives the two's complement value.
    assign psg_ext = {{12{~PSG[15]}}, ~PSG[15], PSG[14:0]};
    assign sum_l   = acc_l + mol_ext;
    assign sum_r   = acc_r + mor_ext;
    assign sum_p   = acc_p + psg_ext;

    // Free-running window count; on the close edge the sums including the current input move to the stage.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            cnt       <= 12'd0;
            acc_l     <= 20'sd0;
            acc_r     <= 20'sd0;
            acc_p     <= 28'sd0;
            stage_l   <= 20'sd0;
            stage_r   <= 20'sd0;
            stage_p   <= 28'sd0;
            stage_vld <= 1'b0;
        end else begin
            stage_vld <= close;
            if (close) begin
                cnt     <= 12'd0;
                stage_l <= sum_l;
                stage_r <= sum_r;
                stage_p <= sum_p;
                acc_l   <= 20'sd0;
                acc_r   <= 20'sd0;
                acc_p   <= 28'sd0;
            end else begin
                cnt   <= cnt + 12'd1;
                acc_l <= sum_l;
                acc_r <= sum_r;
                acc_p <= sum_p;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scale, sum and saturate
    // ------------------------------------------------------------------
    logic signed [28:0] fm_l, fm_r, psg_sc, mix_sum_l, mix_sum_r;
    logic signed [15:0] mix_l, mix_r;
    logic               mix_vld;

    assign fm_l      = $signed({{9{stage_l[19]}}, stage_l}) >>> FM_SHIFT;
    assign fm_r      = $signed({{9{stage_r[19]}}, stage_r}) >>> FM_SHIFT;
    assign psg_sc    = $signed({stage_p[27], stage_p}) >>> PSG_SHIFT;
    assign mix_sum_l = fm_l + psg_sc;
    assign mix_sum_r = fm_r + psg_sc;

    // Mix edge: saturated sum of the staged window, forced to silence by MUTE.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            mix_l   <= 16'sd0;
            mix_r   <= 16'sd0;
            mix_vld <= 1'b0;
        end else begin
            mix_vld <= stage_vld;
            if (stage_vld) begin
                if (MUTE) begin
                    mix_l <= 16'sd0;
                    mix_r <= 16'sd0;
                end else begin
                    mix_l <= sat16(mix_sum_l);
                    mix_r <= sat16(mix_sum_r);
                end
            end
        end
    end

    logic signed [15:0] push_l, push_r;
    logic               push_vld;

`ifdef MD_MIXER_LPF_EN
    // ------------------------------------------------------------------
    // One-pole low-pass: y += (x - y) >>> LPF_SHIFT, saturated to 16 bits
    // ------------------------------------------------------------------
    function automatic logic signed [15:0] lpf_step(input logic signed [15:0] x,
                                                    input logic signed [16:0] y);
        logic signed [18:0] x19, y19, d19, ds19, s19;
        logic signed [28:0] s29;
        x19  = {{3{x[15]}}, x};
        y19  = {{2{y[16]}}, y};
        d19  = x19 - y19;
        ds19 = d19 >>> LPF_SHIFT;
        s19  = y19 + ds19;
        s29  = {{10{s19[18]}}, s19};
        return sat16(s29);
    endfunction

    logic signed [16:0] lpf_y_l, lpf_y_r;
    logic signed [15:0] lpf_next_l, lpf_next_r, filt_l, filt_r;
    logic               filt_vld;

    assign lpf_next_l = lpf_step(mix_l, lpf_y_l);
    assign lpf_next_r = lpf_step(mix_r, lpf_y_r);

    // Filter state advances only when a new mix sample arrives.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            lpf_y_l  <= 17'sd0;
            lpf_y_r  <= 17'sd0;
            filt_l   <= 16'sd0;
            filt_r   <= 16'sd0;
            filt_vld <= 1'b0;
        end else begin
            filt_vld <= mix_vld;
            if (mix_vld) begin
                lpf_y_l <= {lpf_next_l[15], lpf_next_l};
                lpf_y_r <= {lpf_next_r[15], lpf_next_r};
                filt_l  <= lpf_next_l;
                filt_r  <= lpf_next_r;
            end
        end
    end

    assign push_l   = filt_l;
    assign push_r   = filt_r;
    assign push_vld = filt_vld;
`else
    assign push_l   = mix_l;
    assign push_r   = mix_r;
    assign push_vld = mix_vld;
`endif

    // ------------------------------------------------------------------
    // 4-entry first-word fall-through FIFO
    // ------------------------------------------------------------------
    logic [31:0] fifo_mem [4];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  fifo_cnt;
    logic        fifo_full, pop, push, overflow_r;

    assign fifo_full = (fifo_cnt == 3'd4);
    assign pop       = (fifo_cnt != 3'd0) && out_if.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push      = push_vld && (!fifo_full || pop);

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge MCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {push_l, push_r};
        end
    end

    // Pointer/count bookkeeping and the drop pulse.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            fifo_cnt   <= 3'd0;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= push_vld && fifo_full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    logic [31:0] head;
    assign head             = fifo_mem[rd_ptr];
    assign out_if.out_valid = (fifo_cnt != 3'd0);
    assign out_if.out_l     = out_if.out_valid ? head[31:16] : 16'sd0;
    assign out_if.out_r     = out_if.out_valid ? head[15:0]  : 16'sd0;
    assign out_if.overflow  = overflow_r;
endmodule
